// File: rtl/apb_pkg.sv
// Shared definitions for the APB completer: bus widths, register index
// position inside PADDR and the transfer state encoding.
package apb_pkg;
    localparam int APB_ADDR_W  = 8;
    localparam int APB_DATA_W  = 32;
    localparam int REG_IDX_LSB = 2;
    localparam int REG_IDX_W   = APB_ADDR_W - REG_IDX_LSB;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } state_t;
endpackage

// File: rtl/apb_regfile.sv
// Register bank behind the APB completer: index 0 is a read-only ID constant,
// indices 1..NUM_REGS-1 are read/write storage cleared by reset.
module apb_regfile
    import apb_pkg::*;
#(
    parameter int                    NUM_REGS = 16,
    parameter logic [APB_DATA_W-1:0] ID_VALUE = 32'hA11B_0001
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [REG_IDX_W-1:0]  widx,
    input  logic [APB_DATA_W-1:0] wdata,
    input  logic [REG_IDX_W-1:0]  ridx,
    output logic [APB_DATA_W-1:0] rdata
);

    logic [APB_DATA_W-1:0] regs [1:NUM_REGS-1];

    always_ff @(posedge clk) begin
        for (int i = 1; i < NUM_REGS; i++) begin
            if (reset) begin
                regs[i] <= '0;
            end else if (we && widx == REG_IDX_W'(i)) begin
                regs[i] <= wdata;
            end
        end
    end

    // Indices with no backing storage read as zero.
    always_comb begin
        rdata = '0;
        if (ridx == '0) begin
            rdata = ID_VALUE;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (ridx == REG_IDX_W'(i)) begin
                    rdata = regs[i];
                end
            end
        end
    end

endmodule

// File: rtl/apb_slave.sv
// APB completer with a configurable number of wait states; the FSM, wait
// counter and error decode live here, storage lives in apb_regfile.
module apb_slave
    import apb_pkg::*;
#(
    parameter int                    NUM_REGS    = 16,
    parameter int                    WAIT_STATES = 0,
    parameter logic [APB_DATA_W-1:0] ID_VALUE    = 32'hA11B_0001
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [APB_ADDR_W-1:0] PADDR,
    input  logic [APB_DATA_W-1:0] PWDATA,
    output logic                  PREADY,
    output logic [APB_DATA_W-1:0] PRDATA,
    output logic                  PSLVERR
);

    localparam logic [CNT_W-1:0] CNT_INIT =
        (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;
    localparam logic [REG_IDX_W:0] IDX_LIMIT = (REG_IDX_W + 1)'(NUM_REGS);

    state_t                state, next_state;
    logic [CNT_W-1:0]      cnt, cnt_next;
    logic [REG_IDX_W-1:0]  idx_q, idx_next, rd_idx, paddr_idx;
    logic                  wr_q, wr_next;
    logic                  err_q, err_next;
    logic [APB_DATA_W-1:0] wdata_q, wdata_next, reg_rdata;
    logic                  reg_we;
    logic                  unused_addr_bits;

    assign paddr_idx        = PADDR[APB_ADDR_W-1:REG_IDX_LSB];
    assign unused_addr_bits = ^PADDR[REG_IDX_LSB-1:0];

    apb_regfile #(
        .NUM_REGS (NUM_REGS),
        .ID_VALUE (ID_VALUE)
    ) u_regfile (
        .clk   (PCLK),
        .reset (PRESET),
        .we    (reg_we),
        .widx  (idx_q),
        .wdata (wdata_q),
        .ridx  (rd_idx),
        .rdata (reg_rdata)
    );

    // In IDLE the read port looks at the live address so a zero-wait read
    // captures its data on the same edge that latches the index.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        idx_next   = idx_q;
        wr_next    = wr_q;
        wdata_next = wdata_q;
        err_next   = err_q;
        rd_idx     = idx_q;
        reg_we     = 1'b0;
        case (state)
            IDLE: begin
                rd_idx = paddr_idx;
                if (PSEL && !PENABLE) begin
                    idx_next   = paddr_idx;
                    wr_next    = PWRITE;
                    wdata_next = PWDATA;
                    err_next   = ({1'b0, paddr_idx} >= IDX_LIMIT) ||
                                 (PWRITE && paddr_idx == '0);
                    if (WAIT_STATES == 0) begin
                        next_state = READY;
                    end else begin
                        next_state = WAIT;
                        cnt_next   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (!PSEL) begin
                    next_state = IDLE;
                end else if (cnt == '0) begin
                    next_state = READY;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            READY: begin
                next_state = IDLE;
                reg_we     = PSEL && PENABLE && wr_q && !err_q;
            end
            default: next_state = IDLE;
        endcase
    end

    // Response outputs are computed from the next state so they are plain flops.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state   <= IDLE;
            cnt     <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            PREADY  <= 1'b0;
            PRDATA  <= '0;
            PSLVERR <= 1'b0;
        end else begin
            state   <= next_state;
            cnt     <= cnt_next;
            idx_q   <= idx_next;
            wr_q    <= wr_next;
            wdata_q <= wdata_next;
            err_q   <= err_next;
            PREADY  <= (next_state == READY);
            PSLVERR <= (next_state == READY) && err_next;
            PRDATA  <= ((next_state == READY) && !err_next && !wr_next) ? reg_rdata : '0;
        end
    end

endmodule

// File: tb/tb_apb_slave.sv
// Directed bench for apb_slave: three instances (0, 2 and 3 wait states)
// driven from a vector table plus hand-written abort/back-to-back/reset sequences.
module tb_apb_slave;

    localparam int D0 = 0;
    localparam int D2 = 1;
    localparam int D3 = 2;
    localparam int MAX_WAITS = 40;

    typedef struct {
        int          dut;
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_waits;
    } vec_t;

    logic        clk = 1'b0;
    logic        preset  [3];
    logic        psel    [3];
    logic        penable [3];
    logic        pwrite  [3];
    logic [7:0]  paddr   [3];
    logic [31:0] pwdata  [3];
    logic        pready  [3];
    logic [31:0] prdata  [3];
    logic        pslverr [3];

    int num_checks = 0;
    int num_fails  = 0;
    vec_t vecs [13];

    always #5 clk = ~clk;

    apb_slave #(.NUM_REGS(16), .WAIT_STATES(0), .ID_VALUE(32'hA11B_0001)) u_ws0 (
        .PCLK(clk), .PRESET(preset[D0]), .PSEL(psel[D0]), .PENABLE(penable[D0]),
        .PWRITE(pwrite[D0]), .PADDR(paddr[D0]), .PWDATA(pwdata[D0]),
        .PREADY(pready[D0]), .PRDATA(prdata[D0]), .PSLVERR(pslverr[D0]));

    apb_slave #(.NUM_REGS(16), .WAIT_STATES(2), .ID_VALUE(32'hA11B_0001)) u_ws2 (
        .PCLK(clk), .PRESET(preset[D2]), .PSEL(psel[D2]), .PENABLE(penable[D2]),
        .PWRITE(pwrite[D2]), .PADDR(paddr[D2]), .PWDATA(pwdata[D2]),
        .PREADY(pready[D2]), .PRDATA(prdata[D2]), .PSLVERR(pslverr[D2]));

    apb_slave #(.NUM_REGS(16), .WAIT_STATES(3), .ID_VALUE(32'hA11B_0001)) u_ws3 (
        .PCLK(clk), .PRESET(preset[D3]), .PSEL(psel[D3]), .PENABLE(penable[D3]),
        .PWRITE(pwrite[D3]), .PADDR(paddr[D3]), .PWDATA(pwdata[D3]),
        .PREADY(pready[D3]), .PRDATA(prdata[D3]), .PSLVERR(pslverr[D3]));

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Runs one transfer and returns at the negedge of its PREADY cycle with
    // PSEL/PENABLE still high, so a following call is back-to-back.
    task automatic apply_stimulus(input int d, input logic wr, input logic [7:0] addr,
                                  input logic [31:0] wdata, output logic [31:0] rdata,
                                  output logic err, output int waits);
        bit done;
        @(posedge clk); #1;
        psel[d]    = 1'b1;
        penable[d] = 1'b0;
        pwrite[d]  = wr;
        paddr[d]   = addr;
        pwdata[d]  = wdata;
        @(posedge clk); #1;
        penable[d] = 1'b1;
        waits = 0;
        rdata = '0;
        err   = 1'b0;
        done  = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (pready[d]) begin
                rdata = prdata[d];
                err   = pslverr[d];
                done  = 1'b1;
            end else begin
                waits++;
                if (waits > MAX_WAITS) begin
                    waits = -1;
                    done  = 1'b1;
                end else begin
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    task automatic idle_bus(input int d);
        @(posedge clk); #1;
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
    endtask

    task automatic check_quiet(input string name, input int d);
        check_output({name, " pready"},  32'(pready[d]),  32'h0);
        check_output({name, " prdata"},  prdata[d],       32'h0);
        check_output({name, " pslverr"}, 32'(pslverr[d]), 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] rdata;
        logic        err;
        int          waits;
        logic        seen_ready;

        vecs[0]  = '{D0, 1'b0, 8'h00, 32'h0,         32'hA11B_0001, 1'b0, 0};
        vecs[1]  = '{D0, 1'b1, 8'h04, 32'hDEAD_BEEF, 32'h0,         1'b0, 0};
        vecs[2]  = '{D0, 1'b0, 8'h04, 32'h0,         32'hDEAD_BEEF, 1'b0, 0};
        vecs[3]  = '{D0, 1'b1, 8'h40, 32'h1111_1111, 32'h0,         1'b1, 0};
        vecs[4]  = '{D0, 1'b1, 8'h00, 32'h2222_2222, 32'h0,         1'b1, 0};
        vecs[5]  = '{D0, 1'b0, 8'h00, 32'h0,         32'hA11B_0001, 1'b0, 0};
        vecs[6]  = '{D0, 1'b0, 8'h40, 32'h0,         32'h0,         1'b1, 0};
        vecs[7]  = '{D0, 1'b0, 8'h3C, 32'h0,         32'h0,         1'b0, 0};
        vecs[8]  = '{D0, 1'b0, 8'h07, 32'h0,         32'hDEAD_BEEF, 1'b0, 0};
        vecs[9]  = '{D3, 1'b1, 8'h08, 32'h1234_5678, 32'h0,         1'b0, 3};
        vecs[10] = '{D3, 1'b0, 8'h08, 32'h0,         32'h1234_5678, 1'b0, 3};
        vecs[11] = '{D3, 1'b0, 8'h04, 32'h0,         32'h0,         1'b0, 3};
        vecs[12] = '{D2, 1'b1, 8'h0C, 32'hCAFE_0001, 32'h0,         1'b0, 2};

        for (int d = 0; d < 3; d++) begin
            preset[d]  = 1'b1;
            psel[d]    = 1'b0;
            penable[d] = 1'b0;
            pwrite[d]  = 1'b0;
            paddr[d]   = '0;
            pwdata[d]  = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) preset[d] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) check_quiet($sformatf("reset dut%0d", d), d);

        for (int i = 0; i < 13; i++) begin
            apply_stimulus(vecs[i].dut, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                           rdata, err, waits);
            idle_bus(vecs[i].dut);
            check_output($sformatf("vec%0d rdata", i), rdata, vecs[i].exp_rdata);
            check_output($sformatf("vec%0d pslverr", i), 32'(err), 32'(vecs[i].exp_err));
            check_output($sformatf("vec%0d waits", i), 32'(waits), 32'(vecs[i].exp_waits));
        end

        // Abort: PSEL dropped in the first access cycle of a 2-wait write.
        @(posedge clk); #1;
        psel[D2] = 1'b1; penable[D2] = 1'b0; pwrite[D2] = 1'b1;
        paddr[D2] = 8'h0C; pwdata[D2] = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        psel[D2] = 1'b0; penable[D2] = 1'b1;
        seen_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (pready[D2]) seen_ready = 1'b1;
            @(posedge clk); #1;
            penable[D2] = 1'b0;
        end
        check_output("abort no pready", 32'(seen_ready), 32'h0);
        apply_stimulus(D2, 1'b0, 8'h0C, 32'h0, rdata, err, waits);
        idle_bus(D2);
        check_output("abort read rdata", rdata, 32'hCAFE_0001);
        check_output("abort read pslverr", 32'(err), 32'h0);
        check_output("abort read waits", 32'(waits), 32'h2);

        // Back-to-back write then read with no idle cycle between.
        apply_stimulus(D0, 1'b1, 8'h10, 32'h0BAD_F00D, rdata, err, waits);
        check_output("b2b write pslverr", 32'(err), 32'h0);
        check_output("b2b write waits", 32'(waits), 32'h0);
        apply_stimulus(D0, 1'b0, 8'h10, 32'h0, rdata, err, waits);
        idle_bus(D0);
        check_output("b2b read rdata", rdata, 32'h0BAD_F00D);
        check_output("b2b read pslverr", 32'(err), 32'h0);
        check_output("b2b read waits", 32'(waits), 32'h0);

        // Reset asserted during the wait states of a write.
        @(posedge clk); #1;
        psel[D3] = 1'b1; penable[D3] = 1'b0; pwrite[D3] = 1'b1;
        paddr[D3] = 8'h14; pwdata[D3] = 32'h55AA_55AA;
        @(posedge clk); #1;
        penable[D3] = 1'b1;
        @(posedge clk); #1;
        preset[D3] = 1'b1;
        @(posedge clk); #1;
        preset[D3] = 1'b0;
        psel[D3] = 1'b0; penable[D3] = 1'b0;
        @(negedge clk);
        check_quiet("after mid reset", D3);
        apply_stimulus(D3, 1'b0, 8'h14, 32'h0, rdata, err, waits);
        idle_bus(D3);
        check_output("post reset 0x14 rdata", rdata, 32'h0);
        check_output("post reset 0x14 waits", 32'(waits), 32'h3);
        apply_stimulus(D3, 1'b0, 8'h08, 32'h0, rdata, err, waits);
        idle_bus(D3);
        check_output("post reset 0x08 rdata", rdata, 32'h0);
        check_output("post reset 0x08 pslverr", 32'(err), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
